sm_addsub_pipe: RTL

- Pipelined, parametrised sign-magnitude adder/subtractor with a four-way sign mode: p+q, p−q, −p+q, −p−q.
- Adds a valid/ready streaming handshake with backpressure.
- Adds an optional saturating sign-magnitude accumulator fed by selected results.
- Sits between the user-project I/O or logic-analyzer capture and downstream DSP/feature-extraction logic, in the wb_clk_i domain.

---
 rtl/sm_addsub_pipe.sv | 134 +++++++++++++
 1 files changed

// File: rtl/sm_addsub_pipe.sv
// Pipelined sign-magnitude adder/subtractor with a four-way sign mode, a
// valid/ready handshake on both sides and a saturating sign-magnitude
// accumulator fed by selected results.
//
// Ports:
//   wb_clk_i, wb_rst_i        clock, synchronous active-high reset
//   in_valid/in_ready         input beat handshake
//   in_p, in_q                W-bit sign-magnitude operands (bit W-1 = sign)
//   in_mode                   00 p+q, 01 p-q, 10 -p+q, 11 -p-q
//   in_acc                    accumulate this beat's result when it leaves
//   acc_clr                   synchronous accumulator clear
//   out_valid/out_ready       output result handshake
//   out_sum                   W+1-bit sign-magnitude result (bit W = sign)
//   acc_o, acc_sat            accumulator value and sticky saturation flag
module sm_addsub_pipe #(
  parameter int unsigned W     = 18,
  parameter int unsigned ACC_W = 24
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_p,
  input  logic [W-1:0]     in_q,
  input  logic [1:0]       in_mode,
  input  logic             in_acc,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W:0]       out_sum,
  output logic [ACC_W-1:0] acc_o,
  output logic             acc_sat
);

  localparam int unsigned MW = W - 1;
  localparam int unsigned TW = W + 1;
  localparam int unsigned AW = ACC_W + 1;
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};

  // Stage registers
  logic          s1_v_q, s1_sp_q, s1_sq_q, s1_acc_q;
  logic [MW-1:0] s1_pm_q, s1_qm_q;
  logic          s2_v_q, s2_acc_q;
  logic [TW-1:0] s2_sum_q;
  logic          s3_acc_q;

  logic          stall, out_fire;
  logic [TW-1:0] p_tc, q_tc, s2_sum_d;
  logic          s3_neg;
  logic [W-1:0]  s3_mag;
  logic [W:0]    out_sum_d;

  logic [AW-1:0]    acc_tc, add_tc, acc_base, acc_sum;
  logic             acc_neg, sat_hit;
  logic [ACC_W-1:0] acc_mag, acc_mag_clamped;
  logic [ACC_W-1:0] acc_d;

  // Whole pipe freezes while a result waits downstream
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign out_fire = out_valid & out_ready;

  // S2: two's complement conversion and add; -0 naturally maps to 0
  always_comb begin
    p_tc     = s1_sp_q ? (TW'(0) - TW'(s1_pm_q)) : TW'(s1_pm_q);
    q_tc     = s1_sq_q ? (TW'(0) - TW'(s1_qm_q)) : TW'(s1_qm_q);
    s2_sum_d = p_tc + q_tc;
  end

  // S3: back to sign-magnitude; a zero sum has sign bit 0, giving +0
  always_comb begin
    s3_neg    = s2_sum_q[TW-1];
    s3_mag    = W'(s3_neg ? (TW'(0) - s2_sum_q) : s2_sum_q);
    out_sum_d = {s3_neg, s3_mag};
  end

  // Accumulator: clear-then-add, signed sum, magnitude clamp keeps true sign
  always_comb begin
    acc_tc   = acc_o[ACC_W-1] ? (AW'(0) - AW'(acc_o[ACC_W-2:0]))
                              : AW'(acc_o[ACC_W-2:0]);
    add_tc   = out_sum[W] ? (AW'(0) - AW'(out_sum[W-1:0]))
                          : AW'(out_sum[W-1:0]);
    acc_base = acc_clr ? '0 : acc_tc;
    acc_sum  = acc_base + add_tc;
    acc_neg  = acc_sum[AW-1];
    acc_mag  = ACC_W'(acc_neg ? (AW'(0) - acc_sum) : acc_sum);
    sat_hit  = (acc_mag > ACC_MAX);
    acc_mag_clamped = sat_hit ? ACC_MAX : acc_mag;
    acc_d    = {acc_neg, (ACC_W-1)'(acc_mag_clamped)};
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      s1_v_q    <= 1'b0;
      s1_sp_q   <= 1'b0;
      s1_sq_q   <= 1'b0;
      s1_acc_q  <= 1'b0;
      s1_pm_q   <= '0;
      s1_qm_q   <= '0;
      s2_v_q    <= 1'b0;
      s2_acc_q  <= 1'b0;
      s2_sum_q  <= '0;
      s3_acc_q  <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      acc_o     <= '0;
      acc_sat   <= 1'b0;
    end else begin
      if (!stall) begin
        // S1: operands and effective signs
        s1_v_q    <= in_valid;
        s1_pm_q   <= in_p[MW-1:0];
        s1_qm_q   <= in_q[MW-1:0];
        s1_sp_q   <= in_p[W-1] ^ in_mode[1];
        s1_sq_q   <= in_q[W-1] ^ in_mode[0];
        s1_acc_q  <= in_acc;
        s2_v_q    <= s1_v_q;
        s2_sum_q  <= s2_sum_d;
        s2_acc_q  <= s1_acc_q;
        out_valid <= s2_v_q;
        out_sum   <= out_sum_d;
        s3_acc_q  <= s2_acc_q;
      end
      if (out_fire && s3_acc_q) begin
        acc_o   <= acc_d;
        acc_sat <= (acc_sat & ~acc_clr) | sat_hit;
      end else if (acc_clr) begin
        acc_o   <= '0;
        acc_sat <= 1'b0;
      end
    end
  end

endmodule
